div_period_meter: RTL
=====================

Name: div_period_meter

Overview:
- Receive-side companion to the team's clock divider (`contador`).
- Takes a slow, divided clock-like signal `sig_in`, synchronises it into the `clk` domain and measures its period in `clk` cycles.
- Compares each measured period with an expected value, reports lock, counts mismatches and flags a stuck input.
- Sits downstream of any divided-clock source as a frequency/health monitor.

Parameters:
- CNT_W, 8, width of the period counter, `period` and `exp_period`.
- LOCK_N, 4, consecutive matching periods required before `locked` asserts (1..15).
- ERR_W, 8, width of the saturating mismatch counter `err_cnt`.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  divided clock to measure; asynchronous to `clk`.
- exp_period  input  CNT_W  expected period in `clk` cycles.
- period  output  CNT_W  last measured period.
- period_vld  output  1  one-cycle pulse when `period` updates.
- locked  output  1  LOCK_N consecutive periods equal `exp_period`.
- err_cnt  output  ERR_W  saturating count of mismatching periods.
- timeout  output  1  no rising edge within 2^CNT_W-1 cycles of the previous one.
- high_time  output  CNT_W  cycles `sig_in` was high in the last period (see Optional Feature).

Behaviour:
- Reset: rst_n=0 clears all state asynchronously.
  - State is IDLE; synchroniser flops and counters are 0.
  - `period`=0, `period_vld`=0, `locked`=0, `err_cnt`=0, `timeout`=0, `high_time`=0.
  - Reset mid-measurement discards the partial count; the first edge after release only re-arms.
- Synchroniser: two flops (s1, s2), plus s3 for edge detection. Rising edge = s2 & ~s3.
- Latency: if `sig_in` is first sampled high at clk edge N, the edge is detected in cycle N+1→N+2. Registered outputs (`period_vld`, `period`) update at edge N+2.
- State machine, two states:
  - IDLE: the counter is held. On a detected rising edge: counter←1, go to MEASURE. No `period_vld` is generated.
  - MEASURE: the counter increments by 1 every cycle.
  - MEASURE, on a detected rising edge:
    - `period`←counter; `period_vld`=1 for one cycle; counter←1; stay in MEASURE.
    - `timeout`←0.
    - Compare with `exp_period` as sampled in that same cycle.
  - MEASURE, when the counter equals 2^CNT_W-1 with no edge:
    - `timeout`←1 (level) and `locked`←0; match count←0; go to IDLE.
    - `err_cnt` is unchanged.
    - An edge in the same cycle as the counter reaching the maximum wins: it is a valid period of value 2^CNT_W-1, and there is no timeout.
- Match logic:
  - The match counter increments on each period equal to `exp_period`, saturating at LOCK_N. `locked`=1 once it equals LOCK_N.
  - A mismatch: match counter←0, `locked`←0, `err_cnt`+1 saturating at 2^ERR_W-1.
  - `exp_period`=0 never matches.
  - `locked` and `err_cnt` update in the same cycle as `period_vld`.
- A change to `exp_period` mid-period affects only the compare at the next edge.

Optional Feature:
- Macro: DIV_PERIOD_METER_DUTY_EN.
- Defined:
  - A high-time counter counts cycles with s2=1 since the last edge, starting at 1 on the edge cycle.
  - On each `period_vld`, `high_time` ← that count; it saturates at 2^CNT_W-1.
  - `high_time` is cleared in IDLE.
- Undefined: no high-time logic; `high_time` is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- `sig_in` toggling every 4 clk (period 8), `exp_period`=8 → first `period_vld` at the 2nd rising edge with `period`=8. `locked`=1 on the 4th matching `period_vld`; `err_cnt`=0. With DUTY_EN, `high_time`=4.
- Locked at 8; one period stretched to 10 → `period`=10, `locked`=0, `err_cnt`=1. Returns to 8 → `locked` re-asserts after 4 more matches.
- `sig_in` held low after lock, CNT_W=4 → 15 cycles after the last edge: `timeout`=1, `locked`=0, state IDLE. The next edge re-arms without `period_vld`; the following edge clears `timeout` and gives `period_vld`.
- Mismatch every period with ERR_W=2 → `err_cnt` goes 1, 2, 3, then stays at 3.
- rst_n pulsed low mid-period while locked → all outputs 0 immediately (asynchronous). The first post-reset edge gives no `period_vld`; the second gives the correct period.
- Driven by the divider's `clk_div` with SIZE=4 (expected period 32 per the divider's spec), `exp_period`=32 → steady `period`=32, `locked`=1 after 4 periods, `err_cnt`=0.

Source files
------------

// File: rtl/div_period_meter_if.sv
// div_period_meter_if: signal bundle between a divided-clock source/consumer and the period meter.
//   CNT_W : width of the period fields (exp_period, period, high_time)
//   ERR_W : width of the mismatch counter
// The master modport drives sig_in/exp_period and reads the results.
// The slave modport is the meter's side.
interface div_period_meter_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 8
);
    logic             sig_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic             timeout;
    logic [CNT_W-1:0] high_time;

    modport master (
        output sig_in, exp_period,
        input  period, period_vld, locked, err_cnt, timeout, high_time
    );

    modport slave (
        input  sig_in, exp_period,
        output period, period_vld, locked, err_cnt, timeout, high_time
    );
endinterface

// File: rtl/div_period_meter.sv
// div_period_meter: measures the period of a slow divided clock in clk cycles.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   mon.slave  : sig_in/exp_period in; period, period_vld, locked, err_cnt, timeout,
//                high_time out
// sig_in is synchronised (s1, s2) and edge-detected (s3). Each rising edge closes a
// period, which is compared against exp_period to drive lock and the mismatch count.
// No edge for 2^CNT_W-1 cycles raises timeout and drops back to idle.
// Optional macro DIV_PERIOD_METER_DUTY_EN adds the high_time measurement; without it
// high_time is tied to 0.
module div_period_meter #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERR_W  = 8
) (
    input logic               clk,
    input logic               rst_n,
    div_period_meter_if.slave mon
);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [ERR_W-1:0] ErrMax = '1;
    localparam int unsigned      MatchW = 4;
    localparam logic [MatchW-1:0] LockN = MatchW'(LOCK_N);

    typedef enum logic {StIdle, StMeasure} state_e;

    state_e state_q, state_d;

    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_vld_q, period_vld_d;
    logic              timeout_q, timeout_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic rise, period_done, timeout_evt, exp_hit;

    assign rise        = s2_q & ~s3_q;
    assign period_done = (state_q == StMeasure) && rise;
    // An edge in the same cycle the counter tops out is still a valid period.
    assign timeout_evt = (state_q == StMeasure) && !rise && (cnt_q == CntMax);
    assign exp_hit     = (mon.exp_period != '0) && (mon.exp_period == cnt_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (rise) state_d = StMeasure;
            StMeasure: if (timeout_evt) state_d = StIdle;
        endcase
    end

    // Datapath next-state and registered outputs
    always_comb begin
        cnt_d        = cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        timeout_d    = timeout_q;
        match_d      = match_q;
        err_d        = err_q;

        if (rise) begin
            cnt_d = CntOne;
        end else if (timeout_evt) begin
            cnt_d = '0;
        end else if (state_q == StMeasure) begin
            cnt_d = cnt_q + CntOne;
        end

        if (period_done) begin
            period_d     = cnt_q;
            period_vld_d = 1'b1;
            timeout_d    = 1'b0;
            if (exp_hit) begin
                if (match_q != LockN) match_d = match_q + MatchW'(1);
            end else begin
                match_d = '0;
                if (err_q != ErrMax) err_d = err_q + ERR_W'(1);
            end
        end else if (timeout_evt) begin
            timeout_d = 1'b1;
            match_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            match_q      <= '0;
            err_q        <= '0;
        end else begin
            s1_q         <= mon.sig_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            timeout_q    <= timeout_d;
            match_q      <= match_d;
            err_q        <= err_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.period_vld = period_vld_q;
    assign mon.locked     = (match_q == LockN);
    assign mon.err_cnt    = err_q;
    assign mon.timeout    = timeout_q;

`ifdef DIV_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    // hcnt counts s2-high cycles since the last edge; the edge cycle itself counts as 1.
    always_comb begin
        hcnt_d      = hcnt_q;
        high_time_d = high_time_q;
        if (rise) begin
            hcnt_d = CntOne;
        end else if (state_q == StIdle) begin
            hcnt_d = '0;
        end else if (s2_q && (hcnt_q != CntMax)) begin
            hcnt_d = hcnt_q + CntOne;
        end

        if (period_done) begin
            high_time_d = hcnt_q;
        end else if ((state_q == StIdle) || timeout_evt) begin
            high_time_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            high_time_q <= high_time_d;
        end
    end

    assign mon.high_time = high_time_q;
`else
    assign mon.high_time = '0;
`endif
endmodule
